// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address and
// loads the fetched word into the IF/ID register, with stall, redirect and halt control.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_i,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_insn,
  output logic [31:0] id_pc_plus4,
  output logic        id_misaligned,
  output logic [31:0] fetch_count,
  output logic        dbg_state_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc4_q, pc4_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic        pc_misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  // Handshake note: there is no valid/ready pair here. id_valid qualifies the
  // IF/ID slot; stall_i is the consumer's back-pressure and freezes the slot and PC.
  // redirect_valid wins over halt_i, which wins over stall_i.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    idpc_d  = idpc_q;
    insn_d  = insn_q;
    pc4_d   = pc4_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    if (redirect_valid) begin
      // Wrong-path slot is flushed; the slot keeps its old pc/pc_plus4 fields.
      state_d = ST_RUN;
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      insn_d  = NOP_INSN;
      mis_d   = 1'b0;
    end else if (state_q == ST_HALT) begin
      valid_d = 1'b0;
      insn_d  = NOP_INSN;
      mis_d   = 1'b0;
    end else if (halt_i) begin
      state_d = ST_HALT;
      valid_d = 1'b0;
      insn_d  = NOP_INSN;
      mis_d   = 1'b0;
    end else if (!stall_i) begin
      // A misaligned fetch still advances; decode raises the exception from the flag.
      pc_d    = pc_plus4;
      valid_d = 1'b1;
      idpc_d  = pc_q;
      insn_d  = pc_misaligned ? NOP_INSN : idata;
      pc4_d   = pc_plus4;
      mis_d   = pc_misaligned;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      idpc_q  <= 32'h0000_0000;
      insn_q  <= NOP_INSN;
      pc4_q   <= 32'h0000_0000;
      mis_q   <= 1'b0;
      cnt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      idpc_q  <= idpc_d;
      insn_q  <= insn_d;
      pc4_q   <= pc4_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign iaddr         = pc_q;
  assign id_valid      = valid_q;
  assign id_pc         = idpc_q;
  assign id_insn       = insn_q;
  assign id_pc_plus4   = pc4_q;
  assign id_misaligned = mis_q;
  assign fetch_count   = cnt_q;
  assign dbg_state_o   = state_q;

endmodule
